// File: rtl/hack_data_memory_pkg.sv
// Memory map constants and region decode shared by the M-bus responder and its bench.
package hack_data_memory_pkg;

  localparam logic [15:0] RAM_BASE    = 16'h0000;
  localparam logic [15:0] SCREEN_BASE = 16'h4000;
  localparam logic [15:0] KBD_ADDR    = 16'h6000;

  typedef enum logic [1:0] {
    REGION_RAM    = 2'd0,
    REGION_SCREEN = 2'd1,
    REGION_KBD    = 2'd2,
    REGION_NONE   = 2'd3
  } region_t;

  // RAM is 16K-aligned and screen 8K-aligned, so prefix compares suffice.
  function automatic region_t decode_region(input logic [15:0] addr);
    region_t r;
    if (addr[15:14] == RAM_BASE[15:14])
      r = REGION_RAM;
    else if (addr[15:13] == SCREEN_BASE[15:13])
      r = REGION_SCREEN;
    else if (addr == KBD_ADDR)
      r = REGION_KBD;
    else
      r = REGION_NONE;
    return r;
  endfunction

endpackage

// File: rtl/hack_dual_port_ram.sv
// Word RAM: async read + sync write on one address, plus a registered scan read port.
module hack_dual_port_ram #(
  parameter int DEPTH = 16384,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  input  logic [AW-1:0] scan_addr,
  output logic [15:0]   scan_data
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we)
      mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

  // Samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      scan_data <= '0;
    else
      scan_data <= mem[scan_addr];
  end

endmodule

// File: rtl/hack_data_memory.sv
// CPU M-bus data memory: RAM, screen buffer with scan-out, keyboard register, bad-access flag.
module hack_data_memory
  import hack_data_memory_pkg::*;
#(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  input  logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        bad_access
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);

  region_t     region;
  logic [15:0] kbd_reg;
  logic [15:0] ram_rdata;
  logic [15:0] scr_rdata;
  logic [15:0] ram_scan_unused;
  logic        ram_we;
  logic        scr_we;
  logic        bad_now;

  assign region = decode_region(addressM);

  // Gating with reset keeps an edge during reset from committing a write.
  assign ram_we = writeM & reset & (region == REGION_RAM);
  assign scr_we = writeM & reset & (region == REGION_SCREEN);

  assign bad_now = (writeM && (addressM >= KBD_ADDR)) || (addressM > KBD_ADDR);

  hack_dual_port_ram #(.DEPTH(RAM_WORDS)) u_ram (
    .clock     (clock),
    .reset     (reset),
    .we        (ram_we),
    .addr      (addressM[RAM_AW-1:0]),
    .wdata     (outM),
    .rdata     (ram_rdata),
    .scan_addr ('0),
    .scan_data (ram_scan_unused)
  );

  hack_dual_port_ram #(.DEPTH(SCREEN_WORDS)) u_screen (
    .clock     (clock),
    .reset     (reset),
    .we        (scr_we),
    .addr      (addressM[SCR_AW-1:0]),
    .wdata     (outM),
    .rdata     (scr_rdata),
    .scan_addr (scr_addr),
    .scan_data (scr_data)
  );

  always_comb begin
    inM = 16'h0000;
    case (region)
      REGION_RAM:    inM = ram_rdata;
      REGION_SCREEN: inM = scr_rdata;
      REGION_KBD:    inM = kbd_reg;
      default:       inM = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      kbd_reg    <= 16'h0000;
      bad_access <= 1'b0;
    end else begin
      if (kbd_valid)
        kbd_reg <= kbd_code;
      if (bad_now)
        bad_access <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hack_data_memory.sv
// Self-checking bench for hack_data_memory: RAM/screen scoreboard, keyboard, bad-access and reset scenarios.
module tb_hack_data_memory;
  import hack_data_memory_pkg::*;

  logic        clock;
  logic        reset;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        bad_access;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  hack_data_memory dut (
    .clock      (clock),
    .reset      (reset),
    .addressM   (addressM),
    .outM       (outM),
    .writeM     (writeM),
    .inM        (inM),
    .kbd_valid  (kbd_valid),
    .kbd_code   (kbd_code),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .bad_access (bad_access)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; addressM = KBD_ADDR; outM = 16'h0; writeM = 1'b0;
    kbd_valid = 1'b0; kbd_code = 16'h0; scr_addr = 13'h0;
    #3;
    checks++;
    if (scr_data !== 16'h0000) begin failures++; $display("FAIL reset_scr_data got=%h exp=0000", scr_data); end
    checks++;
    if (bad_access !== 1'b0) begin failures++; $display("FAIL reset_bad got=%b exp=0", bad_access); end
    checks++;
    if (inM !== 16'h0000) begin failures++; $display("FAIL reset_kbd got=%h exp=0000", inM); end
    step(); step();
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_ram();
    exp_t e;
    addressM = 16'h0010; outM = 16'h1234; writeM = 1'b1;
    step();
    writeM = 1'b0;
    #1;
    checks++;
    if (inM !== 16'h1234) begin failures++; $display("FAIL ram_readback got=%h exp=1234", inM); end
    checks++;
    if (bad_access !== 1'b0) begin failures++; $display("FAIL ram_bad got=%b exp=0", bad_access); end
    // Scoreboard: RAM and screen writes including both region top boundaries.
    for (int i = 0; i < 12; i++) begin
      if (i < 5)       e.addr = 16'h0100 + 16'(i) * 16'h0123;
      else if (i == 5) e.addr = 16'h3FFF;
      else if (i < 11) e.addr = 16'h4100 + 16'(i) * 16'h0003;
      else             e.addr = 16'h5FFF;
      e.data = 16'($urandom);
      addressM = e.addr; outM = e.data; writeM = 1'b1;
      sb.push_back(e);
      step();
    end
    writeM = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addressM = e.addr;
      #1;
      checks++;
      if (inM !== e.data) begin failures++; $display("FAIL sb_read addr=%h got=%h exp=%h", e.addr, inM, e.data); end
    end
    step();
  endtask

  task automatic test_screen();
    addressM = 16'h4000; outM = 16'h5555; writeM = 1'b1; scr_addr = 13'h0;
    step();
    outM = 16'hFFFF;
    step();
    writeM = 1'b0;
    checks++;
    if (scr_data !== 16'h5555) begin failures++; $display("FAIL scr_rbw_old got=%h exp=5555", scr_data); end
    #1;
    checks++;
    if (inM !== 16'hFFFF) begin failures++; $display("FAIL scr_cpu_read got=%h exp=ffff", inM); end
    step();
    checks++;
    if (scr_data !== 16'hFFFF) begin failures++; $display("FAIL scr_rbw_new got=%h exp=ffff", scr_data); end
    addressM = 16'h4005; outM = 16'hABCD; writeM = 1'b1;
    step();
    writeM = 1'b0; scr_addr = 13'h5;
    step();
    scr_addr = 13'h0;
    checks++;
    if (scr_data !== 16'hABCD) begin failures++; $display("FAIL scr_scan5 got=%h exp=abcd", scr_data); end
    step();
    checks++;
    if (scr_data !== 16'hFFFF) begin failures++; $display("FAIL scr_scan0 got=%h exp=ffff", scr_data); end
  endtask

  task automatic test_bad_access();
    addressM = 16'h0000; outM = 16'h0A0A; writeM = 1'b1;
    step();
    writeM = 1'b0; addressM = KBD_ADDR;
    step();
    checks++;
    if (bad_access !== 1'b0) begin failures++; $display("FAIL bad_read_kbd got=%b exp=0", bad_access); end
    addressM = 16'h6001;
    #1;
    checks++;
    if (inM !== 16'h0000) begin failures++; $display("FAIL bad_inm_6001 got=%h exp=0000", inM); end
    step();
    checks++;
    if (bad_access !== 1'b1) begin failures++; $display("FAIL bad_set_6001 got=%b exp=1", bad_access); end
    addressM = 16'h8000; outM = 16'hDEAD; writeM = 1'b1;
    #1;
    checks++;
    if (inM !== 16'h0000) begin failures++; $display("FAIL bad_inm_8000 got=%h exp=0000", inM); end
    step();
    writeM = 1'b0; addressM = 16'h0000;
    #1;
    checks++;
    if (inM !== 16'h0A0A) begin failures++; $display("FAIL bad_ram0_kept got=%h exp=0a0a", inM); end
    step(); step(); step();
    checks++;
    if (bad_access !== 1'b1) begin failures++; $display("FAIL bad_sticky got=%b exp=1", bad_access); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bad_access !== 1'b0) begin failures++; $display("FAIL bad_cleared got=%b exp=0", bad_access); end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_kbd();
    addressM = KBD_ADDR;
    #1;
    checks++;
    if (inM !== 16'h0000) begin failures++; $display("FAIL kbd_init got=%h exp=0000", inM); end
    kbd_valid = 1'b1; kbd_code = 16'h0041;
    #1;
    checks++;
    if (inM !== 16'h0000) begin failures++; $display("FAIL kbd_same_cycle got=%h exp=0000", inM); end
    step();
    kbd_valid = 1'b0;
    #1;
    checks++;
    if (inM !== 16'h0041) begin failures++; $display("FAIL kbd_load got=%h exp=0041", inM); end
    kbd_valid = 1'b1; kbd_code = 16'h0000;
    step();
    kbd_valid = 1'b0;
    #1;
    checks++;
    if (inM !== 16'h0000) begin failures++; $display("FAIL kbd_release got=%h exp=0000", inM); end
    kbd_valid = 1'b1; kbd_code = 16'h0011;
    step();
    kbd_code = 16'h0022;
    step();
    kbd_code = 16'h0041;
    step();
    kbd_valid = 1'b0;
    #1;
    checks++;
    if (inM !== 16'h0041) begin failures++; $display("FAIL kbd_last_wins got=%h exp=0041", inM); end
    outM = 16'h00FF; writeM = 1'b1;
    step();
    writeM = 1'b0;
    #1;
    checks++;
    if (inM !== 16'h0041) begin failures++; $display("FAIL kbd_cpu_write got=%h exp=0041", inM); end
    checks++;
    if (bad_access !== 1'b1) begin failures++; $display("FAIL kbd_write_bad got=%b exp=1", bad_access); end
  endtask

  task automatic test_reset_mid();
    addressM = 16'h0005; outM = 16'hBEEF; writeM = 1'b1; scr_addr = 13'h0;
    step();
    outM = 16'h1111;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (scr_data !== 16'h0000) begin failures++; $display("FAIL rst_scr_data got=%h exp=0000", scr_data); end
    checks++;
    if (bad_access !== 1'b0) begin failures++; $display("FAIL rst_bad got=%b exp=0", bad_access); end
    step();
    addressM = KBD_ADDR;
    #1;
    checks++;
    if (inM !== 16'h0000) begin failures++; $display("FAIL rst_kbd got=%h exp=0000", inM); end
    writeM = 1'b0; addressM = 16'h0005;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (inM !== 16'hBEEF) begin failures++; $display("FAIL rst_ram_kept got=%h exp=beef", inM); end
    @(posedge clock);
    #1;
    outM = 16'h2222; writeM = 1'b1;
    step();
    writeM = 1'b0;
    #1;
    checks++;
    if (inM !== 16'h2222) begin failures++; $display("FAIL rst_first_edge got=%h exp=2222", inM); end
    checks++;
    if (scr_data !== 16'hFFFF) begin failures++; $display("FAIL rst_scan_resume got=%h exp=ffff", scr_data); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_screen();
    test_bad_access();
    test_kbd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
